// File: rtl/oscar_capture.sv
// oscar_capture: circular ADC capture buffer with pre-trigger history and rising-edge level trigger.
// Define OSCAR_AUTOTRIG_EN to force a trigger after AUTO_TIMEOUT valid samples in WAIT.
module oscar_capture #(
  parameter int DEPTH        = 1024,
  parameter int PRE          = 100,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic                     new_clk,
  input  logic                     reset,
  input  logic [15:0]              adc_data,
  input  logic                     adc_valid,
  input  logic                     arm,
  input  logic [15:0]              trig_level,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [15:0]              rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] trig_ptr,
  output logic                     auto_trig
);
  localparam int AW   = $clog2(DEPTH);
  localparam int POST = DEPTH - PRE;
  localparam int CW   = AW + 1;
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(POST - 1);

  if (AUTO_TIMEOUT < 1 || PRE >= DEPTH || PRE < 0 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
    $error("oscar_capture: invalid DEPTH/PRE/AUTO_TIMEOUT");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   wr_ptr_reg;
  logic [CW-1:0]   cnt_reg;
  logic [15:0]     prev_reg;
  logic            have_prev_reg;
  logic [AW-1:0]   trig_ptr_reg;
  logic [15:0]     rd_data_reg;
  logic            rd_valid_reg;
  logic            capturing;
  logic            wr_en;
  logic            level_hit;
  logic            trig_fire;
  logic            arm_start;
  logic            rd_fire;
  logic [AW-1:0]   rd_phys;
  logic [15:0]     mem [DEPTH];

  assign capturing = (state_reg == S_PRE) || (state_reg == S_WAIT) || (state_reg == S_POST);
  assign wr_en     = capturing && adc_valid;
  assign level_hit = have_prev_reg && (prev_reg < trig_level) && (adc_data >= trig_level);
  assign arm_start = arm && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign rd_fire   = rd_en && (state_reg == S_DONE);
  // Logical address 0 is the oldest pre-trigger sample.
  assign rd_phys   = trig_ptr_reg - AW'(PRE) + rd_addr;

`ifdef OSCAR_AUTOTRIG_EN
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);
  logic [TW-1:0] to_cnt_reg;
  logic          auto_trig_reg;
  logic          timeout_hit;
  assign timeout_hit = (to_cnt_reg == TW'(AUTO_TIMEOUT - 1));
  assign trig_fire   = (state_reg == S_WAIT) && adc_valid && (level_hit || timeout_hit);
  assign auto_trig   = auto_trig_reg;
`else
  assign trig_fire   = (state_reg == S_WAIT) && adc_valid && level_hit;
  assign auto_trig   = 1'b0;
`endif

  always_ff @(posedge new_clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (arm) state_next = (PRE == 0) ? S_WAIT : S_PRE;
      S_PRE:          if (adc_valid && cnt_reg == PRE_LAST) state_next = S_WAIT;
      S_WAIT:         if (trig_fire) state_next = (POST == 1) ? S_DONE : S_POST;
      S_POST:         if (adc_valid && cnt_reg == POST_LAST) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = capturing;
    done = (state_reg == S_DONE);
  end

  always_ff @(posedge new_clk) begin
    if (reset || arm_start) begin
      wr_ptr_reg    <= '0;
      cnt_reg       <= '0;
      prev_reg      <= '0;
      have_prev_reg <= 1'b0;
`ifdef OSCAR_AUTOTRIG_EN
      to_cnt_reg    <= '0;
      auto_trig_reg <= 1'b0;
`endif
      if (reset) trig_ptr_reg <= '0;
    end else if (wr_en) begin
      wr_ptr_reg    <= wr_ptr_reg + AW'(1);
      prev_reg      <= adc_data;
      have_prev_reg <= 1'b1;
      case (state_reg)
        S_PRE:  cnt_reg <= (cnt_reg == PRE_LAST) ? '0 : cnt_reg + CW'(1);
        S_WAIT: begin
          if (trig_fire) begin
            trig_ptr_reg <= wr_ptr_reg;
            cnt_reg      <= CW'(1);
`ifdef OSCAR_AUTOTRIG_EN
            auto_trig_reg <= !level_hit;
`endif
          end
`ifdef OSCAR_AUTOTRIG_EN
          else begin
            to_cnt_reg <= to_cnt_reg + TW'(1);
          end
`endif
        end
        S_POST:  cnt_reg <= cnt_reg + CW'(1);
        default: ;
      endcase
    end
  end

  // Sample storage is deliberately never reset.
  always_ff @(posedge new_clk) begin
    if (wr_en) mem[wr_ptr_reg] <= adc_data;
  end

  always_ff @(posedge new_clk) begin
    if (reset) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_fire;
      if (rd_fire) rd_data_reg <= mem[rd_phys];
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign trig_ptr = trig_ptr_reg;
endmodule

// File: tb/tb_oscar_capture.sv
// Directed self-checking bench for oscar_capture (DEPTH=1024, PRE=100, AUTO_TIMEOUT=10).
module tb_oscar_capture;
  localparam int DEPTH = 1024;
  localparam int PRE   = 100;
  localparam int AW    = 10;

  logic          new_clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   adc_data = '0;
  logic          adc_valid = 1'b0;
  logic          arm = 1'b0;
  logic [15:0]   trig_level = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [15:0]   rd_data;
  logic          rd_valid;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_ptr;
  logic          auto_trig;

  int checks = 0;
  int failures = 0;

  always #5 new_clk = ~new_clk;

  oscar_capture #(.DEPTH(DEPTH), .PRE(PRE), .AUTO_TIMEOUT(10)) dut (
    .new_clk(new_clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
    .arm(arm), .trig_level(trig_level), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .trig_ptr(trig_ptr), .auto_trig(auto_trig)
  );

  task automatic step();
    @(posedge new_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic read(input int addr, input int exp);
    rd_addr = AW'(addr);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check($sformatf("rd_valid@%0d", addr), 32'(rd_valid), 1);
    check($sformatf("rd_data@%0d", addr), 32'(rd_data), exp);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_trig_ptr", 32'(trig_ptr), 0);
    check("rst_auto_trig", 32'(auto_trig), 0);
    reset = 1'b0;

    // Ramp capture; arm during WAIT and rd_en before done are both ignored
    trig_level = 16'd500;
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("ramp_busy_after_arm", 32'(busy), 1);
    for (int n = 0; n < 1424; n++) begin
      adc_data = 16'(n);
      adc_valid = 1'b1;
      arm = (n == 200);
      rd_en = (n == 300);
      step();
      if (n == 99)   check("ramp_wait_busy", 32'(busy), 1);
      if (n == 300)  check("rd_before_done", 32'(rd_valid), 0);
      if (n == 500)  check("ramp_trig_ptr", 32'(trig_ptr), 500);
      if (n == 1422) check("ramp_done_early", 32'(done), 0);
    end
    adc_valid = 1'b0;
    arm = 1'b0;
    rd_en = 1'b0;
    check("ramp_done", 32'(done), 1);
    check("ramp_busy_off", 32'(busy), 0);
    read(0, 400);
    read(100, 500);
    read(1023, 1423);
    step();
    check("rd_valid_drop", 32'(rd_valid), 0);
    check("rd_data_hold", 32'(rd_data), 1423);

    // rd_en with arm in DONE: read completes and capture restarts
    rd_addr = AW'(100);
    rd_en = 1'b1;
    arm = 1'b1;
    step();
    rd_en = 1'b0;
    arm = 1'b0;
    check("rearm_rd_valid", 32'(rd_valid), 1);
    check("rearm_rd_data", 32'(rd_data), 500);
    check("rearm_busy", 32'(busy), 1);

    // Ramp with adc_valid toggling; invalid cycles carry a value above the level
    for (int k = 0; k < 2847; k++) begin
      adc_valid = (k % 2 == 0);
      adc_data = adc_valid ? 16'(k / 2) : 16'hFFFF;
      step();
      if (k == 2845) check("toggle_done_early", 32'(done), 0);
    end
    adc_valid = 1'b0;
    check("toggle_done", 32'(done), 1);
    check("toggle_trig_ptr", 32'(trig_ptr), 500);
    read(1023, 1423);
    read(0, 400);

    // Constant 0x8000 above a 0x4000 level: no rising crossing
    trig_level = 16'h4000;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 0; i < 1033; i++) begin
      adc_data = 16'h8000;
      adc_valid = 1'b1;
      step();
`ifdef OSCAR_AUTOTRIG_EN
      if (i == 1031) check("auto_done_early", 32'(done), 0);
`endif
    end
    adc_valid = 1'b0;
`ifdef OSCAR_AUTOTRIG_EN
    check("auto_done", 32'(done), 1);
    check("auto_trig_set", 32'(auto_trig), 1);
    check("auto_trig_ptr", 32'(trig_ptr), 109);
`else
    check("const_done", 32'(done), 0);
    check("const_busy", 32'(busy), 1);
    check("const_auto_trig", 32'(auto_trig), 0);
`endif

    // Reset during POST, overriding a simultaneous arm
    reset = 1'b1;
    step();
    reset = 1'b0;
    trig_level = 16'd500;
    arm = 1'b1;
    step();
    arm = 1'b0;
    for (int n = 0; n < 600; n++) begin
      adc_data = 16'(n);
      adc_valid = 1'b1;
      step();
    end
    check("post_busy", 32'(busy), 1);
    check("post_trig_ptr", 32'(trig_ptr), 500);
    reset = 1'b1;
    arm = 1'b1;
    adc_data = 16'd600;
    step();
    reset = 1'b0;
    adc_valid = 1'b0;
    check("postrst_busy", 32'(busy), 0);
    check("postrst_done", 32'(done), 0);
    check("postrst_trig_ptr", 32'(trig_ptr), 0);
    check("postrst_auto_trig", 32'(auto_trig), 0);
    check("postrst_rd_valid", 32'(rd_valid), 0);
    check("postrst_rd_data", 32'(rd_data), 0);
    step();
    arm = 1'b0;
    check("restart_busy", 32'(busy), 1);
    for (int n = 0; n <= 500; n++) begin
      adc_data = 16'(n);
      adc_valid = 1'b1;
      step();
    end
    adc_valid = 1'b0;
    check("restart_trig_ptr", 32'(trig_ptr), 500);
    check("restart_busy_post", 32'(busy), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/oscar_capture.md
OSCAR_CAPTURE -- requirements
Module: oscar_capture

Interface
REQ-001 Parameters (name, default, meaning) SHALL be exactly these three lines:
- DEPTH, 1024, buffer depth in 16-bit samples; power of two.
- PRE, 100, pre-trigger samples kept, at most DEPTH-1.
- AUTO_TIMEOUT, 65535, valid samples in WAIT before a forced trigger; used only with the configuration macro.
REQ-002 Derived constants: AW = log2(DEPTH); POST = DEPTH - PRE is the post-trigger sample count, trigger sample included.
REQ-003 Ports (name, direction, width, meaning) SHALL be exactly these lines:
- new_clk, in, 1, sole clock; all logic on its rising edge.
- reset, in, 1, synchronous active-high reset.
- adc_data, in, 16, unsigned ADC sample.
- adc_valid, in, 1, adc_data is valid this cycle.
- arm, in, 1, capture start request.
- trig_level, in, 16, unsigned trigger threshold.
- rd_en, in, 1, readback request.
- rd_addr, in, AW, logical readback address.
- rd_data, out, 16, readback sample.
- rd_valid, out, 1, rd_data valid.
- busy, out, 1, high in PRE, WAIT and POST.
- done, out, 1, high in DONE.
- trig_ptr, out, AW, physical buffer address of the trigger sample.
- auto_trig, out, 1, last trigger was forced by timeout.

Function
REQ-004 The FSM SHALL have states IDLE, PRE, WAIT, POST and DONE; busy = PRE|WAIT|POST and done = DONE.
REQ-005 IDLE or DONE with arm=1: next state PRE; wr_ptr, sample counter, prev-sample register, auto_trig and the timeout counter clear to 0.
REQ-006 arm in PRE, WAIT or POST SHALL be ignored.
REQ-007 In PRE, WAIT and POST, each cycle with adc_valid=1 SHALL write adc_data to buffer[wr_ptr] and advance wr_ptr by 1 mod DEPTH, wrapping DEPTH-1 to 0.
REQ-008 adc_valid=0 SHALL advance no pointer, counter or state.
REQ-009 PRE SHALL move to WAIT on the same edge that writes the PRE-th sample.
REQ-010 Trigger in WAIT: valid sample with prev < trig_level and adc_data >= trig_level (unsigned).
REQ-011 prev SHALL be the last valid sample since arm; with no such sample, no trigger.
REQ-012 On trigger, that sample SHALL be written; trig_ptr = its address; state POST; post count 1.
REQ-013 POST SHALL move to DONE on the edge that writes the POST-th post-trigger sample; DONE writes nothing.
REQ-014 DONE with rd_en=1: next cycle rd_data = buffer[(trig_ptr - PRE + rd_addr) mod DEPTH] and rd_valid=1; else rd_valid=0 and rd_data holds.
REQ-015 Logical map: addresses 0..PRE-1 are pre-trigger samples oldest first, PRE is the trigger sample, and PRE+1..DEPTH-1 follow.
REQ-016 rd_en outside DONE SHALL give rd_valid=0.
REQ-017 rd_en and arm in the same DONE cycle: the read SHALL complete and the state SHALL move to PRE.

Reset
REQ-018 reset=1 at a clock edge SHALL force IDLE from any state, including mid-capture, and override arm.
REQ-019 Reset SHALL clear to 0: rd_data, rd_valid, busy, done, trig_ptr, auto_trig, wr_ptr and all counters.
REQ-020 Buffer contents SHALL not be reset.

Configuration
REQ-021 With OSCAR_AUTOTRIG_EN defined: in WAIT, the AUTO_TIMEOUT-th consecutive valid sample with no trigger SHALL be treated as the trigger per REQ-012 and set auto_trig=1.
REQ-022 A REQ-010 trigger on that same sample SHALL take priority and leave auto_trig=0.
REQ-023 Without OSCAR_AUTOTRIG_EN: no timeout logic; auto_trig is tied to 0; WAIT lasts until a REQ-010 trigger.

Verification
REQ-024 The bench SHALL cover these six directed scenarios:
- Ramp 0,1,2,... every cycle, trig_level=500, arm: trigger on value 500; trig_ptr=500; done after sample 1423; logical read 0 -> 400, 100 -> 500, 1023 -> 1423, each with rd_valid one cycle after rd_en.
- Constant 0x8000 with level 0x4000: never triggers; done stays 0; busy stays 1; auto_trig=0 (macro off).
- Same with the macro on and AUTO_TIMEOUT=10: forced trigger on the 10th WAIT sample; auto_trig=1; done follows.
- adc_valid toggling 1,0,1,0 during a ramp: write count and trigger address match the REQ-024 ramp case.
- Reset asserted in POST: next cycle busy=0, done=0, trig_ptr=0; arm restarts capture.
- arm during WAIT is ignored; arm in DONE recaptures; rd_en before done gives rd_valid=0.
